// File: rtl/key_result_collector.sv
// key_result_collector
//   Collects results from the parallel RC4 key-search cores. While searching it
//   watches every core's found/done flags, latches the key and index of the
//   winning core (lowest index wins on a tie), raises stop_all to halt every
//   core, and flags exhaustion when all cores finish without a match. It also
//   drives a value for the HEX displays and counts elapsed search cycles.
//
// Ports
//   clk         in   system clock
//   reset       in   synchronous, active-high; wins over every other input
//   start       in   level; IDLE -> SEARCH when high, ignored afterwards
//   core_key    in   core i current key at [i*KEY_W +: KEY_W]
//   core_found  in   core i found the correct key (held high by the core)
//   core_done   in   core i exhausted its slice without a match
//   stop_all    out  halt all cores (FOUND or EXHAUSTED)
//   key_valid   out  found_key/found_core are valid
//   found_key   out  latched winning key
//   found_core  out  index of the winning core
//   exhausted   out  every core finished, no key found
//   busy        out  high while in SEARCH
//   display     out  value for HEX displays
//   cycles      out  elapsed SEARCH cycles, saturating
//   dbg_state   out  current FSM state (IDLE=0, SEARCH=1, FOUND=2, EXHAUSTED=3)
//
// Handshake: there is no valid/ready pair. start is a level that is sampled
// only in IDLE; stop_all is a level that, once high, stays high until reset.
// key_valid qualifies found_key/found_core and is likewise sticky until reset.

module key_result_collector #(
  parameter int CORE_COUNT_LOG_2 = 2,
  parameter int CORE_COUNT       = 2 ** CORE_COUNT_LOG_2,
  parameter int KEY_W            = 22,
  parameter int CYC_W            = 32
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          start,
  input  logic [CORE_COUNT*KEY_W-1:0]   core_key,
  input  logic [CORE_COUNT-1:0]         core_found,
  input  logic [CORE_COUNT-1:0]         core_done,
  output logic                          stop_all,
  output logic                          key_valid,
  output logic [KEY_W-1:0]              found_key,
  output logic [CORE_COUNT_LOG_2-1:0]   found_core,
  output logic                          exhausted,
  output logic                          busy,
  output logic [KEY_W-1:0]              display,
  output logic [CYC_W-1:0]              cycles,
  output logic [1:0]                    dbg_state
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    SEARCH    = 2'd1,
    FOUND     = 2'd2,
    EXHAUSTED = 2'd3
  } state_t;

  state_t state;

  assign dbg_state = state;

  // Winner selection: scan from the highest index down so the lowest asserting
  // core is the last assignment and therefore wins.
  logic                        win_any;
  logic [CORE_COUNT_LOG_2-1:0] win_idx;
  logic [KEY_W-1:0]            win_key;

  always_comb begin
    win_any = |core_found;
    win_idx = '0;
    for (int i = CORE_COUNT - 1; i >= 0; i--) begin
      if (core_found[i]) begin
        win_idx = CORE_COUNT_LOG_2'(i);
      end
    end
    win_key = core_key[win_idx*KEY_W +: KEY_W];
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      stop_all   <= 1'b0;
      key_valid  <= 1'b0;
      found_key  <= '0;
      found_core <= '0;
      exhausted  <= 1'b0;
      busy       <= 1'b0;
      display    <= '0;
      cycles     <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state  <= SEARCH;
            busy   <= 1'b1;
            cycles <= '0;
          end
        end

        SEARCH: begin
          // The edge that ends the search still counts; the value then freezes.
          if (cycles != {CYC_W{1'b1}}) begin
            cycles <= cycles + CYC_W'(1);
          end
          display <= core_key[KEY_W-1:0];

          // A found on any core takes priority over a simultaneous all-done.
          if (win_any) begin
            state      <= FOUND;
            found_key  <= win_key;
            found_core <= win_idx;
            key_valid  <= 1'b1;
            stop_all   <= 1'b1;
            busy       <= 1'b0;
            display    <= win_key;
          end else if (&core_done) begin
            state     <= EXHAUSTED;
            exhausted <= 1'b1;
            stop_all  <= 1'b1;
            busy      <= 1'b0;
            display   <= {KEY_W{1'b1}};
          end
        end

        // Terminal states: everything holds until reset.
        FOUND:     state <= FOUND;
        EXHAUSTED: state <= EXHAUSTED;

        default: state <= IDLE;
      endcase
    end
  end

endmodule
